// File: rtl/mac_pkg.sv
// Shared definitions for the MAC processing elements: Booth digit codes,
// accumulator saturation limits and partial-product count.
package mac_pkg;

  localparam int MAX_ACC_W = 128;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_POS1,
    BOOTH_POS2,
    BOOTH_NEG1,
    BOOTH_NEG2
  } booth_e;

  function automatic int npp(input int w);
    return w / 2;
  endfunction

  // bits = {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_e booth_enc(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return BOOTH_POS1;
      3'b011:         return BOOTH_POS2;
      3'b100:         return BOOTH_NEG2;
      3'b101, 3'b110: return BOOTH_NEG1;
      default:        return BOOTH_ZERO;
    endcase
  endfunction

  // Limits are built wide and truncated to the accumulator width by the caller.
  function automatic logic [MAX_ACC_W-1:0] sat_max(input int n);
    logic [MAX_ACC_W-1:0] r;
    r = '0;
    for (int i = 0; i < n - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_ACC_W-1:0] sat_min(input int n);
    logic [MAX_ACC_W-1:0] r;
    r = '0;
    r[n-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mac_pe_pipe_if.sv
// Operand/result bundle of one MAC processing element, including the
// operand forwarding towards the east and south neighbours.
interface mac_pe_pipe_if #(
  parameter int W     = 16,
  parameter int ACC_W = 40
);
  logic                    in_valid;
  logic signed [W-1:0]     a;
  logic signed [W-1:0]     b;
  logic                    acc_clr;
  logic                    last;
  logic signed [W-1:0]     a_out;
  logic signed [W-1:0]     b_out;
  logic                    valid_out;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_ovf;

  modport master (
    output in_valid, a, b, acc_clr, last,
    input  a_out, b_out, valid_out, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, a, b, acc_clr, last,
    output a_out, b_out, valid_out, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/mac_cska.sv
// Carry-skip adder built from 4-bit carry-lookahead blocks; N must be a
// multiple of 4. Result is modulo 2^N.
module mac_cska #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s
);
  localparam int NB = N / 4;

  logic [NB-1:0] c;
  assign c[0] = 1'b0;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [3:0] p;
    logic [2:0] g;
    logic [3:0] ci;

    assign p     = x[4*k +: 4] ^ y[4*k +: 4];
    assign g     = x[4*k +: 3] & y[4*k +: 3];
    assign ci[0] = c[k];
    assign ci[1] = g[0] | (p[0] & c[k]);
    assign ci[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c[k]);
    assign ci[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c[k]);
    assign s[4*k +: 4] = p ^ ci;

    // Block carry-out: local generate, or the incoming carry skipped across
    // a fully propagating block.
    if (k < NB - 1) begin : g_skip
      assign c[k+1] = (x[4*k+3] & y[4*k+3]) | (p[3] & g[2]) | (&p[3:2] & g[1])
                    | (&p[3:1] & g[0]) | (&p & c[k]);
    end
  end
endmodule

// File: rtl/mac_mult_cs.sv
// Radix-4 Booth multiplier front end: W/2 sign-extended partial products
// reduced by a chain of 3:2 full-adder compressors to two carry-save rows.
module mac_mult_cs
  import mac_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] row0,
  output logic [2*W-1:0] row1
);
  localparam int NPP = npp(W);
  localparam int PW  = 2 * W;

  logic [PW-1:0] a_ext;
  logic [W:0]    b_ext;
  logic [PW-1:0] pp [NPP];

  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {b, 1'b0};

  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      case (booth_enc(b_ext[2*i +: 3]))
        BOOTH_POS1: pp[i] = a_ext;
        BOOTH_POS2: pp[i] = a_ext << 1;
        BOOTH_NEG1: pp[i] = -a_ext;
        BOOTH_NEG2: pp[i] = -(a_ext << 1);
        default:    pp[i] = '0;
      endcase
      pp[i] = pp[i] << (2 * i);
    end
  end

  // NOTE: blocking assignments here are deliberate: s/c are running
  // intermediates of one combinational evaluation, not stored state.
  always_comb begin
    logic [PW-1:0] s, c, t;
    s = pp[0];
    c = pp[1];
    for (int i = 2; i < NPP; i++) begin
      t = s ^ c ^ pp[i];
      c = ((s & c) | (s & pp[i]) | (c & pp[i])) << 1;
      s = t;
    end
    row0 = s;
    row1 = c;
  end
endmodule

// File: rtl/mac_pe_pipe.sv
// Two-stage pipelined signed MAC processing element: S1 multiplies into
// carry-save rows, S2 resolves the product and accumulates with optional saturation.
module mac_pe_pipe
  import mac_pkg::*;
#(
  parameter int W     = 16,
  parameter int ACC_W = 40,
  parameter bit SAT   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  mac_pe_pipe_if.slave    bus
);
  localparam int PW = 2 * W;
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic [PW-1:0]    row0, row1, s1_row0, s1_row1, prod;
  logic             s1_valid, s1_clr, s1_last;
  logic [ACC_W-1:0] acc, base, prod_ext, sum, acc_nxt;
  logic             sticky, sticky_nxt, ovf;

  mac_mult_cs #(.W(W)) u_mult (
    .a    (bus.a),
    .b    (bus.b),
    .row0 (row0),
    .row1 (row1)
  );

  // NOTE: the carry-save rows carry no reset; they are only consumed when
  // the matching stage valid is set, and that valid is reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_row0 <= row0;
      s1_row1 <= row1;
    end
  end

  // NOTE: every registered signal uses non-blocking assignment so all
  // registers sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_clr        <= 1'b0;
      s1_last       <= 1'b0;
      bus.a_out     <= '0;
      bus.b_out     <= '0;
      bus.valid_out <= 1'b0;
    end else if (en) begin
      s1_valid      <= bus.in_valid;
      s1_clr        <= bus.in_valid & bus.acc_clr;
      s1_last       <= bus.in_valid & bus.last;
      bus.a_out     <= bus.a;
      bus.b_out     <= bus.b;
      bus.valid_out <= bus.in_valid;
    end
  end

  mac_cska #(.N(PW)) u_final_add (
    .x (s1_row0),
    .y (s1_row1),
    .s (prod)
  );

  assign prod_ext = ACC_W'(signed'(prod));
  assign base     = s1_clr ? '0 : acc;

  mac_cska #(.N(ACC_W)) u_acc_add (
    .x (base),
    .y (prod_ext),
    .s (sum)
  );

  // Operands of equal sign producing a result of the other sign overflowed.
  assign ovf        = (base[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
  assign acc_nxt    = (SAT && ovf) ? (prod_ext[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
  assign sticky_nxt = ovf | (sticky & ~s1_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      sticky        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_acc   <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (en) begin
      bus.out_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc    <= acc_nxt;
        sticky <= sticky_nxt;
        if (s1_last) begin
          bus.out_acc <= acc_nxt;
          bus.out_ovf <= sticky_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_pe_pipe.sv
// Scoreboard bench: one stimulus stream drives three PEs (40-bit saturating,
// 32-bit saturating, 32-bit wrapping); a behavioural model predicts each report.
module tb_mac_pe_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, en, in_valid, acc_clr, last;
  logic signed [W-1:0] a, b;

  always #5 clk = ~clk;

  mac_pe_pipe_if #(.W(W), .ACC_W(40)) bus0 ();
  mac_pe_pipe_if #(.W(W), .ACC_W(32)) bus1 ();
  mac_pe_pipe_if #(.W(W), .ACC_W(32)) bus2 ();

  assign bus0.in_valid = in_valid; assign bus0.a = a; assign bus0.b = b;
  assign bus0.acc_clr  = acc_clr;  assign bus0.last = last;
  assign bus1.in_valid = in_valid; assign bus1.a = a; assign bus1.b = b;
  assign bus1.acc_clr  = acc_clr;  assign bus1.last = last;
  assign bus2.in_valid = in_valid; assign bus2.a = a; assign bus2.b = b;
  assign bus2.acc_clr  = acc_clr;  assign bus2.last = last;

  mac_pe_pipe #(.W(W), .ACC_W(40), .SAT(1'b1)) dut0 (.clk(clk), .rst(rst), .en(en), .bus(bus0));
  mac_pe_pipe #(.W(W), .ACC_W(32), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .en(en), .bus(bus1));
  mac_pe_pipe #(.W(W), .ACC_W(32), .SAT(1'b0)) dut2 (.clk(clk), .rst(rst), .en(en), .bus(bus2));

  logic signed [63:0] obs_acc [3];
  logic               obs_v   [3];
  logic               obs_o   [3];
  assign obs_acc[0] = 64'(bus0.out_acc); assign obs_v[0] = bus0.out_valid; assign obs_o[0] = bus0.out_ovf;
  assign obs_acc[1] = 64'(bus1.out_acc); assign obs_v[1] = bus1.out_valid; assign obs_o[1] = bus1.out_ovf;
  assign obs_acc[2] = 64'(bus2.out_acc); assign obs_v[2] = bus2.out_valid; assign obs_o[2] = bus2.out_ovf;

  int aw      [3] = '{40, 32, 32};
  bit sat_cfg [3] = '{1'b1, 1'b1, 1'b0};

  typedef struct packed {
    logic [2:0][63:0] acc;
    logic [2:0]       ovf;
    int               due;
  } exp_t;

  exp_t   sb_q [$];
  exp_t   cur;
  longint m_acc [3];
  bit     m_st  [3];
  bit     exp_v, edge_en, mon_on;
  int     en_cnt, n_tests, n_fail;
  logic signed [W-1:0] pt_a, pt_b;
  logic                pt_v;

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_st[k]  = 1'b0;
    end
    sb_q.delete();
    cur   = '0;
    exp_v = 1'b0;
    pt_a  = '0;
    pt_b  = '0;
    pt_v  = 1'b0;
  endtask

  task automatic model_step(input longint p, input bit clr, input bit lst);
    exp_t   e;
    longint base, sum, mx, mn;
    bit     o;
    e = '0;
    e.due = en_cnt + 1;
    for (int k = 0; k < 3; k++) begin
      mx   = (longint'(1) <<< (aw[k] - 1)) - 1;
      mn   = -mx - 1;
      base = clr ? 0 : m_acc[k];
      sum  = base + p;
      o    = (sum > mx) || (sum < mn);
      if (o) begin
        if (sat_cfg[k]) sum = (p < 0) ? mn : mx;
        else            sum = (sum > mx) ? sum - 2 * (mx + 1) : sum + 2 * (mx + 1);
      end
      m_st[k]   = clr ? o : (m_st[k] | o);
      m_acc[k]  = sum;
      e.acc[k]  = sum;
      e.ovf[k]  = m_st[k];
    end
    if (lst) sb_q.push_back(e);
  endtask

  // One clock cycle: apply inputs, update the model at the edge, return at negedge.
  task automatic drive(input bit v, input int av, input int bv, input bit clr, input bit lst,
                       input bit e = 1'b1);
    in_valid = v; a = W'(av); b = W'(bv); acc_clr = clr; last = lst; en = e;
    @(posedge clk);
    edge_en = e && !rst;
    if (edge_en) begin
      en_cnt++;
      pt_a = a; pt_b = b; pt_v = v;
      if (v) model_step(longint'(a) * longint'(b), clr, lst);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_valid%0d", tag, k), obs_v[k], 0);
      check($sformatf("%s_acc%0d", tag, k), obs_acc[k], 0);
      check($sformatf("%s_ovf%0d", tag, k), obs_o[k], 0);
    end
    check({tag, "_a_out"}, bus0.a_out, 0);
    check({tag, "_b_out"}, bus0.b_out, 0);
    check({tag, "_valid_out"}, bus0.valid_out, 0);
  endtask

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (edge_en) begin
        exp_v = (sb_q.size() > 0) && (sb_q[0].due == en_cnt);
        if (exp_v) cur = sb_q.pop_front();
      end
      for (int k = 0; k < 3; k++) begin
        check($sformatf("out_valid%0d", k), obs_v[k], exp_v);
        check($sformatf("out_acc%0d", k), obs_acc[k], $signed(cur.acc[k]));
        check($sformatf("out_ovf%0d", k), obs_o[k], cur.ovf[k]);
      end
      check("a_out", bus0.a_out, pt_a);
      check("b_out", bus0.b_out, pt_b);
      check("valid_out", bus0.valid_out, pt_v);
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; en_cnt = 0; edge_en = 1'b0; mon_on = 1'b0;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; a = '0; b = '0; acc_clr = 1'b0; last = 1'b0;
    model_clear();
    @(negedge clk);
    check_zero("reset");
    #2 rst = 1'b0;
    mon_on = 1'b1;
    idle(2);

    // Single element: 3 * -5
    drive(1'b1, 3, -5, 1'b1, 1'b1);
    idle(3);

    // Four-element dot product, back-to-back
    drive(1'b1, 100, 200, 1'b1, 1'b0);
    drive(1'b1, -300, 7, 1'b0, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b0);
    drive(1'b1, -32768, -32768, 1'b0, 1'b1);
    idle(3);

    // Same elements with bubbles (one carrying ignored clr/last) and stalls
    drive(1'b1, 100, 200, 1'b1, 1'b0);
    drive(1'b0, 9, 9, 1'b1, 1'b1);
    drive(1'b1, -300, 7, 1'b0, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, -32768, -32768, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Overflow in the 32-bit instances, then a fresh dot product
    drive(1'b1, 32767, 32767, 1'b1, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b1);
    drive(1'b1, 1, 1, 1'b1, 1'b1);
    idle(3);

    // Back-to-back dot products with no gap
    drive(1'b1, 2, 3, 1'b1, 1'b1);
    drive(1'b1, 4, 5, 1'b1, 1'b0);
    drive(1'b1, 6, 7, 1'b0, 1'b1);
    idle(3);

    // Random dot products with random bubbles and stalls
    for (int d = 0; d < 6; d++) begin
      for (int i = 0; i < 6; i++) begin
        drive(1'b1, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
              i == 0, i == 5, $urandom_range(3) != 0);
        if ($urandom_range(3) == 0) drive(1'b0, 0, 0, 1'b0, 1'b0);
      end
    end
    idle(3);

    // Asynchronous reset with a report in flight
    drive(1'b1, 7, 9, 1'b1, 1'b0);
    drive(1'b1, 2, 2, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1 check_zero("async_rst");
    model_clear();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    idle(4);
    drive(1'b1, 5, -6, 1'b1, 1'b1);
    idle(3);

    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_pe_pipe.md
# mac_pe_pipe

Parametrised, two-stage pipelined signed multiply-accumulate processing element for the systolic MAC array.
- Multiplies W-bit signed operands with a radix-4 Booth / carry-save tree.
- Accumulates into an ACC_W-bit signed accumulator, with optional saturation and a sticky overflow flag.
- Brackets dot products with explicit clear and last markers, and forwards operands to the neighbouring PE.
- Adds a global stall enable and valid qualification, which the fixed 16-bit PE lacks.

## Interface
Parameters:
- W, 16, operand width; even, 8..32
- ACC_W, 40, accumulator width; multiple of 4, ≥ 2*W
- SAT, 1, 1 = saturate accumulator on signed overflow, 0 = wrap

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-high
- en  in  1  global stall; 0 freezes every register in the block
- in_valid  in  1  a/b/acc_clr/last qualify this cycle
- a  in  W  signed multiplicand
- b  in  W  signed multiplier
- acc_clr  in  1  first element of a dot product; accumulator restarts from 0
- last  in  1  final element of a dot product
- a_out  out  W  registered a, to the east neighbour
- b_out  out  W  registered b, to the south neighbour
- valid_out  out  1  registered in_valid, to the neighbours
- out_valid  out  1  one-cycle pulse; out_acc/out_ovf are valid
- out_acc  out  ACC_W  signed dot-product result
- out_ovf  out  1  overflow occurred in the reported dot product

## Operation
- Stage S1, multiply:
  - Booth radix-4 encoding of b yields W/2 partial products, each 2*W wide and sign-extended.
  - A full-adder tree reduces them to two carry-save rows.
  - Rows, valid, clr and last are registered.
- Stage S2, accumulate:
  - prod = row0 + row1, taken modulo 2^(2W) and sign-extended to ACC_W.
  - base = clr ? 0 : acc.
  - sum = base + prod.
  - Signed overflow is detected from the sign bits of base, prod and sum.
  - With SAT=1, an overflowing sum clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), by the sign of prod.
  - With SAT=0, the sum wraps.
- ovf_sticky is set by any overflowing S2 update and reset by clr (clr takes the current element's overflow as the new value).
- When S2 is valid with last=1:
  - out_acc <= sum, out_ovf <= sticky including the current element, out_valid <= 1.
  - acc is still updated to sum.
- out_valid is a single-cycle pulse. out_acc and out_ovf hold their value until the next report.
- S2 updates only when its stage valid is 1; bubbles leave acc and sticky untouched.
- acc_clr and last are ignored when in_valid=0.
- acc_clr and last high together form a one-element dot product: out_acc = a*b.
- Pass-through: a_out/b_out/valid_out <= a/b/in_valid every enabled cycle, independent of the MAC path.
- en=0 holds all pipeline, accumulator, pass-through and output registers, and forces out_valid to hold its current value.
- Reset clears all outputs, acc, sticky and stage valids to 0 immediately and asynchronously. In-flight elements are discarded.

## Timing
- Input sampled at enabled edge t:
  - S1 registered at t.
  - acc updated at enabled edge t+1.
  - out_valid high in the cycle after edge t+1, i.e. latency 2 enabled cycles.
- Pass-through latency: 1 enabled cycle.
- Throughput: one element per enabled cycle; no back-pressure.
- Consecutive dot products need no gap:
  - last on element k and acc_clr on element k+1 in adjacent cycles is legal.
  - The second result excludes every element of the first.
- Stall cycles (en=0) add latency 1:1 and never lose or duplicate an element.

## Structure
- Shared package mac_pkg holds:
  - Booth digit codes (0, ±1, ±2).
  - Saturation-limit constant functions sat_max(ACC_W) and sat_min(ACC_W).
  - The partial-product count function npp(W) = W/2.
- Sub-module mac_mult_cs(W): combinational Booth encoder plus carry-save tree, producing row0/row1. It is reused by future PE variants.
- The final adder and accumulator adder are carry-skip adders built from 4-bit CLA blocks.

## Test plan
- Reset: assert rst asynchronously mid-stream → all outputs 0 in the same cycle, no out_valid afterwards until new clr…last elements are sent.
- Single element (W=16, ACC_W=40): a=3, b=-5, acc_clr=last=1 → out_acc=-15, out_ovf=0, out_valid for exactly 1 cycle, 2 cycles after input.
- Four-element dot product: (100,200), (-300,7), (32767,32767), (-32768,-32768) back-to-back → out_acc=2147436013, out_ovf=0.
- Same four elements with in_valid gaps and two en=0 cycles mid-stream → same out_acc, with out_valid delayed by exactly the inserted bubble and stall count. a_out/b_out follow the inputs 1 enabled cycle later.
- Overflow (ACC_W=32): three elements of (32767,32767):
  - SAT=1 → out_acc=2147483647, out_ovf=1.
  - SAT=0 → out_acc=-1073938429, out_ovf=1.
  - A following dot product with acc_clr reports out_ovf=0.
- Back-to-back dot products: (2,3) with clr+last, then (4,5),(6,7) with clr on the first and last on the second → out_acc=6, then out_acc=62, in consecutive reports.
